// File: rtl/pipe_controller.sv
// Pipelined RV32I control: decode in D, carry control fields through E/M/W, resolve PCSrc in E.
// Define MEXT_EN to accept the RV32M multiply encodings (funct7=0000001, funct3 000..011).
module pipe_controller #(
    parameter int ALUCTL_W = 4,
    parameter int IMM_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                FlushE,
    input  logic                ZeroE,
    input  logic                LtE,
    input  logic                LtuE,
    output logic [IMM_W-1:0]    ImmSrcD,
    output logic                IllegalD,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                ALUSrcE,
    output logic                JalrE,
    output logic                PCSrcE,
    output logic                ResultSrcE0,
    output logic                RegWriteM,
    output logic                MemWriteM,
    output logic [2:0]          Funct3M,
    output logic                RegWriteW,
    output logic [1:0]          ResultSrcW,
    output logic                IllegalSeen
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic [3:0] w_alu_func;
    logic [3:0] w_alu_code;
    logic [2:0] w_imm_code;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_branch;
    logic       w_jump;
    logic       w_jalr;
    logic       w_alu_src;
    logic [1:0] w_result_src;
    logic       w_illegal;
    logic       w_cond;

    logic [ALUCTL_W-1:0] r_alu_ctl_e;
    logic       r_alu_src_e;
    logic       r_jalr_e;
    logic       r_jump_e;
    logic       r_branch_e;
    logic       r_reg_write_e;
    logic       r_mem_write_e;
    logic [1:0] r_result_src_e;
    logic [2:0] r_funct3_e;
    logic       r_reg_write_m;
    logic       r_mem_write_m;
    logic [1:0] r_result_src_m;
    logic [2:0] r_funct3_m;
    logic       r_reg_write_w;
    logic [1:0] r_result_src_w;
    logic       r_illegal_seen;

    // funct3 -> ALU op shared by R and I-ALU; sub only exists in the R form
    always_comb begin
        w_alu_func = 4'd0;
        case (funct3)
            3'b000:  w_alu_func = (op == OP_R && funct7[5]) ? 4'd1 : 4'd0;
            3'b001:  w_alu_func = 4'd7;
            3'b010:  w_alu_func = 4'd5;
            3'b011:  w_alu_func = 4'd6;
            3'b100:  w_alu_func = 4'd4;
            3'b101:  w_alu_func = funct7[5] ? 4'd9 : 4'd8;
            3'b110:  w_alu_func = 4'd3;
            default: w_alu_func = 4'd2;
        endcase
    end

    always_comb begin
        w_alu_code   = 4'd0;
        w_imm_code   = 3'b000;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_jalr       = 1'b0;
        w_alu_src    = 1'b0;
        w_result_src = 2'b00;
        w_illegal    = 1'b0;
        case (op)
            OP_R: begin
                w_reg_write = 1'b1;
                w_alu_code  = w_alu_func;
                if (funct7 == 7'b0000000) begin
                    w_illegal = 1'b0;
                end else if (funct7 == 7'b0100000) begin
                    w_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
`ifdef MEXT_EN
                end else if (funct7 == 7'b0000001 && !funct3[2]) begin
                    w_alu_code = 4'd10 + {2'b00, funct3[1:0]};
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_I: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_code  = w_alu_func;
                // funct7 is immediate data except for the shift forms
                if (funct3 == 3'b001)
                    w_illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    w_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
            end
            OP_STORE: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm_code  = 3'b001;
            end
            OP_BR: begin
                w_branch   = 1'b1;
                w_alu_code = 4'd1;
                w_imm_code = 3'b010;
                w_illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                w_jump       = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
                w_imm_code   = 3'b011;
            end
            OP_JALR: begin
                w_jump       = 1'b1;
                w_jalr       = 1'b1;
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b10;
            end
            OP_LUI: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b11;
                w_imm_code   = 3'b100;
            end
            default: w_illegal = 1'b1;
        endcase
        // an illegal encoding travels down the pipe as a bubble
        if (w_illegal) begin
            w_alu_code   = 4'd0;
            w_imm_code   = 3'b000;
            w_reg_write  = 1'b0;
            w_mem_write  = 1'b0;
            w_branch     = 1'b0;
            w_jump       = 1'b0;
            w_jalr       = 1'b0;
            w_alu_src    = 1'b0;
            w_result_src = 2'b00;
        end
    end

    assign ImmSrcD  = IMM_W'(w_imm_code);
    assign IllegalD = w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_ctl_e    <= '0;
            r_alu_src_e    <= 1'b0;
            r_jalr_e       <= 1'b0;
            r_jump_e       <= 1'b0;
            r_branch_e     <= 1'b0;
            r_reg_write_e  <= 1'b0;
            r_mem_write_e  <= 1'b0;
            r_result_src_e <= 2'b00;
            r_funct3_e     <= 3'b000;
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_funct3_m     <= 3'b000;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 2'b00;
            r_illegal_seen <= 1'b0;
        end else begin
            if (FlushE) begin
                r_alu_ctl_e    <= '0;
                r_alu_src_e    <= 1'b0;
                r_jalr_e       <= 1'b0;
                r_jump_e       <= 1'b0;
                r_branch_e     <= 1'b0;
                r_reg_write_e  <= 1'b0;
                r_mem_write_e  <= 1'b0;
                r_result_src_e <= 2'b00;
                r_funct3_e     <= 3'b000;
            end else begin
                r_alu_ctl_e    <= ALUCTL_W'(w_alu_code);
                r_alu_src_e    <= w_alu_src;
                r_jalr_e       <= w_jalr;
                r_jump_e       <= w_jump;
                r_branch_e     <= w_branch;
                r_reg_write_e  <= w_reg_write;
                r_mem_write_e  <= w_mem_write;
                r_result_src_e <= w_result_src;
                r_funct3_e     <= funct3;
            end
            r_reg_write_m  <= r_reg_write_e;
            r_mem_write_m  <= r_mem_write_e;
            r_result_src_m <= r_result_src_e;
            r_funct3_m     <= r_funct3_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
            r_illegal_seen <= r_illegal_seen | (w_illegal & ~FlushE);
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_funct3_e)
            3'b000:  w_cond = ZeroE;
            3'b001:  w_cond = ~ZeroE;
            3'b100:  w_cond = LtE;
            3'b101:  w_cond = ~LtE;
            3'b110:  w_cond = LtuE;
            3'b111:  w_cond = ~LtuE;
            default: w_cond = 1'b0;
        endcase
    end

    assign PCSrcE      = r_jump_e | (r_branch_e & w_cond);
    assign ALUControlE = r_alu_ctl_e;
    assign ALUSrcE     = r_alu_src_e;
    assign JalrE       = r_jalr_e;
    assign ResultSrcE0 = r_result_src_e[0];
    assign RegWriteM   = r_reg_write_m;
    assign MemWriteM   = r_mem_write_m;
    assign Funct3M     = r_funct3_m;
    assign RegWriteW   = r_reg_write_w;
    assign ResultSrcW  = r_result_src_w;
    assign IllegalSeen = r_illegal_seen;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: hand-computed control values at each pipeline stage.
// Expected values for the multiply encoding follow MEXT_EN as defined for the build.
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       FlushE, ZeroE, LtE, LtuE;
    logic [2:0] ImmSrcD;
    logic       IllegalD;
    logic [3:0] ALUControlE;
    logic       ALUSrcE, JalrE, PCSrcE, ResultSrcE0;
    logic       RegWriteM, MemWriteM;
    logic [2:0] Funct3M;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;
    logic       IllegalSeen;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_controller #(.ALUCTL_W(4), .IMM_W(3)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .JalrE(JalrE), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .IllegalSeen(IllegalSeen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op     = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        rst = 1'b1; FlushE = 1'b1; ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        drive(7'b0000000, 3'b000, 7'b0000000);
        tick(); tick();
        check("rst_RegWriteW", 32'(RegWriteW), 0);
        check("rst_ResultSrcW", 32'(ResultSrcW), 0);
        check("rst_ALUControlE", 32'(ALUControlE), 0);
        check("rst_PCSrcE", 32'(PCSrcE), 0);
        check("rst_MemWriteM", 32'(MemWriteM), 0);
        check("rst_JalrE", 32'(JalrE), 0);
        check("rst_IllegalSeen", 32'(IllegalSeen), 0);

        // reset outranks an illegal op presented with no flush
        FlushE = 1'b0;
        drive(7'b1111111, 3'b000, 7'b0000000);
        tick();
        check("rst_over_illegal", 32'(IllegalSeen), 0);

        // add then sub
        rst = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0000000);
        settle();
        check("add_IllegalD", 32'(IllegalD), 0);
        tick();
        check("add_ALUControlE", 32'(ALUControlE), 0);
        check("add_ALUSrcE", 32'(ALUSrcE), 0);
        check("add_RegWriteM_early", 32'(RegWriteM), 0);
        drive(7'b0110011, 3'b000, 7'b0100000);
        tick();
        check("sub_ALUControlE", 32'(ALUControlE), 1);
        check("add_RegWriteM", 32'(RegWriteM), 1);
        FlushE = 1'b1;
        tick();
        check("add_RegWriteW", 32'(RegWriteW), 1);
        check("add_ResultSrcW", 32'(ResultSrcW), 0);
        check("bubble_ALUControlE", 32'(ALUControlE), 0);

        // xor with funct7=0100000 is illegal; srai is legal
        drive(7'b0110011, 3'b100, 7'b0100000);
        settle();
        check("xor_f7_IllegalD", 32'(IllegalD), 1);
        FlushE = 1'b0;
        drive(7'b0010011, 3'b101, 7'b0100000);
        settle();
        check("srai_IllegalD", 32'(IllegalD), 0);
        check("srai_ImmSrcD", 32'(ImmSrcD), 0);
        tick();
        check("srai_ALUControlE", 32'(ALUControlE), 9);
        check("srai_ALUSrcE", 32'(ALUSrcE), 1);

        // branches
        drive(7'b1100011, 3'b000, 7'b0000000);
        settle();
        check("beq_ImmSrcD", 32'(ImmSrcD), 2);
        tick();
        ZeroE = 1'b1; settle();
        check("beq_taken", 32'(PCSrcE), 1);
        check("beq_ALUControlE", 32'(ALUControlE), 1);
        ZeroE = 1'b0; settle();
        check("beq_not_taken", 32'(PCSrcE), 0);
        drive(7'b1100011, 3'b110, 7'b0000000);
        tick();
        LtuE = 1'b1; settle();
        check("bltu_taken", 32'(PCSrcE), 1);
        LtuE = 1'b0; settle();
        check("bltu_not_taken", 32'(PCSrcE), 0);
        check("bltu_JalrE", 32'(JalrE), 0);
        drive(7'b1100011, 3'b001, 7'b0000000);
        tick();
        check("bne_taken", 32'(PCSrcE), 1);

        // lw unflushed, then lw flushed on entry to E
        drive(7'b0000011, 3'b010, 7'b0000000);
        tick();
        check("lw_ResultSrcE0", 32'(ResultSrcE0), 1);
        check("lw_PCSrcE", 32'(PCSrcE), 0);
        FlushE = 1'b1;
        tick();
        check("flush_ResultSrcE0", 32'(ResultSrcE0), 0);
        check("flush_ALUSrcE", 32'(ALUSrcE), 0);
        check("lw_RegWriteM", 32'(RegWriteM), 1);
        tick();
        check("flush_RegWriteM", 32'(RegWriteM), 0);
        check("flush_MemWriteM", 32'(MemWriteM), 0);
        check("lw_RegWriteW", 32'(RegWriteW), 1);
        check("lw_ResultSrcW", 32'(ResultSrcW), 1);
        tick();
        check("flush_RegWriteW", 32'(RegWriteW), 0);
        check("flush_ResultSrcW", 32'(ResultSrcW), 0);

        // sw followed by jalr
        FlushE = 1'b0;
        drive(7'b0100011, 3'b010, 7'b0000000);
        settle();
        check("sw_ImmSrcD", 32'(ImmSrcD), 1);
        tick();
        drive(7'b1100111, 3'b000, 7'b0000000);
        tick();
        check("sw_MemWriteM", 32'(MemWriteM), 1);
        check("sw_Funct3M", 32'(Funct3M), 2);
        check("sw_RegWriteM", 32'(RegWriteM), 0);
        check("jalr_JalrE", 32'(JalrE), 1);
        check("jalr_PCSrcE", 32'(PCSrcE), 1);
        check("jalr_ALUSrcE", 32'(ALUSrcE), 1);
        FlushE = 1'b1;
        tick();
        check("jalr_MemWriteM", 32'(MemWriteM), 0);
        check("jalr_RegWriteM", 32'(RegWriteM), 1);
        check("bubble_JalrE", 32'(JalrE), 0);
        tick();
        check("jalr_ResultSrcW", 32'(ResultSrcW), 2);
        check("jalr_RegWriteW", 32'(RegWriteW), 1);

        // illegal opcode: flushed first, then latched
        drive(7'b1111111, 3'b000, 7'b0000000);
        settle();
        check("ill_IllegalD", 32'(IllegalD), 1);
        tick();
        check("ill_flushed_Seen", 32'(IllegalSeen), 0);
        FlushE = 1'b0;
        tick();
        check("ill_Seen", 32'(IllegalSeen), 1);
        check("ill_ALUControlE", 32'(ALUControlE), 0);
        check("ill_PCSrcE", 32'(PCSrcE), 0);
        FlushE = 1'b1;
        tick(); tick();
        check("ill_RegWriteW", 32'(RegWriteW), 0);
        check("ill_Seen_held", 32'(IllegalSeen), 1);

        // reset mid-stream discards the sub in E
        FlushE = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0100000);
        tick();
        check("pre_rst_ALUControlE", 32'(ALUControlE), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_ALUControlE", 32'(ALUControlE), 0);
        check("mid_rst_RegWriteM", 32'(RegWriteM), 0);
        check("mid_rst_IllegalSeen", 32'(IllegalSeen), 0);
        rst = 1'b0;

        // mulh encoding
        drive(7'b0110011, 3'b001, 7'b0000001);
        settle();
`ifdef MEXT_EN
        check("mulh_IllegalD", 32'(IllegalD), 0);
`else
        check("mulh_IllegalD", 32'(IllegalD), 1);
`endif
        tick();
`ifdef MEXT_EN
        check("mulh_ALUControlE", 32'(ALUControlE), 11);
`else
        check("mulh_ALUControlE", 32'(ALUControlE), 0);
`endif
        FlushE = 1'b1;
        tick(); tick();
`ifdef MEXT_EN
        check("mulh_RegWriteW", 32'(RegWriteW), 1);
        check("mulh_IllegalSeen", 32'(IllegalSeen), 0);
`else
        check("mulh_RegWriteW", 32'(RegWriteW), 0);
        check("mulh_IllegalSeen", 32'(IllegalSeen), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
